// File: rtl/rose_pkg.sv
// rose_pkg: shared register-file constants and address type for the Rose datapath
package rose_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int ZERO_REG   = 0;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: writeback, reserve and dual read-port bundle of the scoreboarded register file
interface regfile_sb_if #(
    parameter int DATA_W = rose_pkg::DATA_W_DEF,
    parameter int ADDR_W = rose_pkg::ADDR_W_DEF
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_err;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_a;
    logic              busy_b;
    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr_a, rd_addr_b,
        input  rsv_err, rd_data_a, rd_data_b, busy_a, busy_b
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr_a, rd_addr_b,
        output rsv_err, rd_data_a, rd_data_b, busy_a, busy_b
    );
endinterface

// File: rtl/regfile_sb_rdport.sv
// regfile_sb_rdport: registered read port; REGFILE_BYPASS_EN forwards same-cycle writeback and reserve
module regfile_sb_rdport
    import rose_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                                clk,
    input  logic                                clear,
    input  logic [ADDR_W-1:0]                   i_addr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]    i_vals,
    input  logic [2**ADDR_W-1:0]                i_busy,
    input  logic [2**ADDR_W-1:0]                i_busy_nxt,
    input  logic                                i_wr,
    input  logic [ADDR_W-1:0]                   i_wr_addr,
    input  logic [DATA_W-1:0]                   i_wr_data,
    output logic [DATA_W-1:0]                   o_data,
    output logic                                o_busy
);
    logic [DATA_W-1:0] w_data;
    logic              w_busy;
    logic              w_unused;
`ifdef REGFILE_BYPASS_EN
    assign w_unused = ^i_busy;
    // forward writeback data and the post-update busy bit
    always_comb begin
        w_data = (i_wr && i_wr_addr == i_addr) ? i_wr_data : i_vals[i_addr];
        w_busy = i_busy_nxt[i_addr];
    end
`else
    assign w_unused = ^{i_busy_nxt, i_wr, i_wr_addr, i_wr_data};
    // read-before-write: pre-edge array contents and busy bit
    always_comb begin
        w_data = i_vals[i_addr];
        w_busy = i_busy[i_addr];
    end
`endif
    // register the selected data; the zero register always reads as idle zero
    always_ff @(posedge clk) begin
        if (clear || i_addr == ADDR_W'(ZERO_REG)) begin
            o_data <= '0;
            o_busy <= 1'b0;
        end else begin
            o_data <= w_data;
            o_busy <= w_busy;
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register busy scoreboard; optional bypass via REGFILE_BYPASS_EN
module regfile_sb
    import rose_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic         clk,
    input logic         clear,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DEPTH-1:0][DATA_W-1:0] r_vals;
    logic [DEPTH-1:0]             r_busy;
    logic [DEPTH-1:0]             w_busy_nxt;
    logic                         r_rsv_err;
    logic                         w_wr;
    logic                         w_rsv_req;
    logic                         w_rsv_ok;
    assign w_wr      = bus.wr_en && bus.wr_addr != ADDR_W'(ZERO_REG);
    assign w_rsv_req = bus.rsv_en && bus.rsv_addr != ADDR_W'(ZERO_REG);
    assign w_rsv_ok  = w_rsv_req && (!r_busy[bus.rsv_addr] || (w_wr && bus.wr_addr == bus.rsv_addr));
    assign bus.rsv_err = r_rsv_err;
    // writeback releases its register, an accepted reserve claims one; reserve wins on a tie
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr) w_busy_nxt[bus.wr_addr] = 1'b0;
        if (w_rsv_ok) w_busy_nxt[bus.rsv_addr] = 1'b1;
    end
    // array, scoreboard and reject pulse update; clear drops everything including pending writes
    always_ff @(posedge clk) begin
        if (clear) begin
            r_vals    <= '0;
            r_busy    <= '0;
            r_rsv_err <= 1'b0;
        end else begin
            if (w_wr) r_vals[bus.wr_addr] <= bus.wr_data;
            r_busy    <= w_busy_nxt;
            r_rsv_err <= w_rsv_req && !w_rsv_ok;
        end
    end
    regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
        .clk(clk), .clear(clear), .i_addr(bus.rd_addr_a), .i_vals(r_vals), .i_busy(r_busy),
        .i_busy_nxt(w_busy_nxt), .i_wr(w_wr), .i_wr_addr(bus.wr_addr), .i_wr_data(bus.wr_data),
        .o_data(bus.rd_data_a), .o_busy(bus.busy_a)
    );
    regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
        .clk(clk), .clear(clear), .i_addr(bus.rd_addr_b), .i_vals(r_vals), .i_busy(r_busy),
        .i_busy_nxt(w_busy_nxt), .i_wr(w_wr), .i_wr_addr(bus.wr_addr), .i_wr_data(bus.wr_data),
        .o_data(bus.rd_data_b), .o_busy(bus.busy_b)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus corner-case sequences for regfile_sb
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        logic        clr;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        re;
        logic [2:0]  ra;
        logic [2:0]  aa;
        logic [2:0]  ab;
        logic [15:0] ea;
        logic        eba;
        logic [15:0] eb;
        logic        ebb;
        logic        eerr;
    } vec_t;
    logic clk = 1'b0;
    logic clear = 1'b1;
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus ();
    regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut (.clk(clk), .clear(clear), .bus(bus));
    always #5 clk = ~clk;
    function automatic vec_t mk(logic clr, logic we, logic [2:0] wa, logic [15:0] wd, logic re,
                                logic [2:0] ra, logic [2:0] aa, logic [2:0] ab, logic [15:0] ea,
                                logic eba, logic [15:0] eb, logic ebb, logic eerr);
        vec_t v;
        v.clr = clr; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.aa = aa; v.ab = ab;
        v.ea = ea; v.eba = eba; v.eb = eb; v.ebb = ebb; v.eerr = eerr;
        return v;
    endfunction
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask
    task automatic run(input vec_t v, input string tag);
        clear = v.clr;
        bus.wr_en = v.we; bus.wr_addr = v.wa; bus.wr_data = v.wd;
        bus.rsv_en = v.re; bus.rsv_addr = v.ra;
        bus.rd_addr_a = v.aa; bus.rd_addr_b = v.ab;
        @(posedge clk);
        #1;
        chk({tag, ".rd_data_a"}, bus.rd_data_a, v.ea);
        chk({tag, ".busy_a"}, 16'(bus.busy_a), 16'(v.eba));
        chk({tag, ".rd_data_b"}, bus.rd_data_b, v.eb);
        chk({tag, ".busy_b"}, 16'(bus.busy_b), 16'(v.ebb));
        chk({tag, ".rsv_err"}, 16'(bus.rsv_err), 16'(v.eerr));
    endtask
    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        //                clr we wa wd        re ra aa ab  ea        eba eb        ebb err
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 7, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 6, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 2, 5, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 3, 4, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h1234, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 5, 1, 2, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 5, 0, 5, 16'h0000, 0, 16'h0000, 1, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 5, 5, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 1, 5, 16'h00AA, 0, 0, 1, 1, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 5, 5, 16'h00AA, 0, 16'h00AA, 0, 0));
        tbl.push_back(mk(0, 1, 2, 16'h0F0F, 1, 2, 1, 5, 16'h0000, 0, 16'h00AA, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h0F0F, 1, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 2, 0, 2, 16'h0000, 0, 16'h0F0F, 1, 1));
        tbl.push_back(mk(0, 1, 7, 16'hFFFF, 0, 0, 6, 5, 16'h0000, 0, 16'h00AA, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 7, 7, 16'hFFFF, 0, 16'hFFFF, 0, 0));
        for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));
        // same-cycle write/read of r3: forwarded only with bypass
        run(mk(0, 1, 3, 16'hBEEF, 0, 0, 3, 0, BYP ? 16'hBEEF : 16'h0000, 0, 16'h0000, 0, 0), "beef_same");
        run(mk(0, 0, 0, 16'h0000, 0, 0, 3, 3, 16'hBEEF, 0, 16'hBEEF, 0, 0), "beef_next");
        // write and reserve r4 together while reading it
        run(mk(0, 1, 4, 16'h4444, 1, 4, 4, 0, BYP ? 16'h4444 : 16'h0000, BYP, 16'h0000, 0, 0), "wr_rsv_same");
        run(mk(0, 0, 0, 16'h0000, 0, 0, 4, 4, 16'h4444, 1, 16'h4444, 1, 0), "wr_rsv_next");
        // reserve visibility on the read of the same cycle
        run(mk(0, 0, 0, 16'h0000, 1, 1, 0, 1, 16'h0000, 0, 16'h0000, BYP, 0), "rsv_same");
        run(mk(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 1, 0), "rsv_next");
        // clear with reservations pending, a write to r1 and a would-be rejected reserve of r6
        run(mk(0, 0, 0, 16'h0000, 1, 6, 6, 1, 16'h0000, BYP, 16'h0000, 1, 0), "rsv_r6");
        run(mk(1, 1, 1, 16'h5555, 1, 6, 1, 6, 16'h0000, 0, 16'h0000, 0, 0), "clear_cyc");
        run(mk(0, 0, 0, 16'h0000, 0, 0, 1, 6, 16'h0000, 0, 16'h0000, 0, 0), "post_clr_r1r6");
        run(mk(0, 0, 0, 16'h0000, 0, 0, 2, 4, 16'h0000, 0, 16'h0000, 0, 0), "post_clr_r2r4");
        run(mk(0, 0, 0, 16'h0000, 0, 0, 3, 7, 16'h0000, 0, 16'h0000, 0, 0), "post_clr_r3r7");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register busy scoreboard, the successor to the fixed 8×16 register file in the Rose datapath. It provides two registered read ports, one write port and one reservation port so the issue stage can mark a destination register as pending until writeback. Register 0 is hardwired to zero. An optional write-to-read bypass forwards same-cycle writeback data to the read ports.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; depth = 2**ADDR_W

Ports:
- clk  in  1  rising-edge clock, single clock domain
- clear  in  1  synchronous, active-high reset
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback register
- wr_data  in  DATA_W  writeback data
- rsv_en  in  1  reserve request from issue
- rsv_addr  in  ADDR_W  register to mark busy
- rsv_err  out  1  registered; pulses when a reserve is rejected
- rd_addr_a / rd_addr_b  in  ADDR_W  read addresses
- rd_data_a / rd_data_b  out  DATA_W  registered read data
- busy_a / busy_b  out  1  registered busy flags for the read addresses

## Operation
- Storage: `vals[0..2**ADDR_W-1]` of DATA_W bits, plus `busy[0..2**ADDR_W-1]`.
- Write:
  - When wr_en=1 and wr_addr!=0, `vals[wr_addr]` is updated and `busy[wr_addr]` is cleared.
  - A write to a non-busy register is legal; busy stays 0.
  - A write to address 0 is ignored.
- Reserve:
  - When rsv_en=1, rsv_addr!=0 and `busy[rsv_addr]`=0, set `busy[rsv_addr]`.
  - A reserve to address 0 is a no-op. It does not set busy and does not raise rsv_err.
  - A reserve to an already-busy register is rejected and rsv_err=1 next cycle.
  - Exception: if a write to that same address occurs in the same cycle, the reserve is accepted.
- Simultaneous write and reserve to the same address: the write updates data, and the final busy bit is 1 (reserve wins).
- Reads:
  - Address 0 always returns 0 data and busy=0.
  - Otherwise the read returns `vals[addr]` and `busy[addr]`, subject to the bypass rules in Configuration.
  - Port A and port B may use the same address.
- Clear:
  - Zeroes every `vals` entry, every busy bit, and all outputs (rd_data_a/b=0, busy_a/b=0, rsv_err=0).
  - Clear overrides a write and a reserve in the same cycle.

## Timing
- All outputs are registered on the rising edge of clk.
- Read latency is 1 cycle: the address presented in cycle N appears on rd_data/busy in cycle N+1.
- A write in cycle N is visible through the array in cycle N+2 for a read addressed in cycle N+1. Same-cycle visibility depends on REGFILE_BYPASS_EN.
- A reserve in cycle N is visible on busy_x in cycle N+1 for a read addressed in cycle N. With bypass off, it is visible one cycle later.
- rsv_err is a single-cycle pulse in cycle N+1 for a rejection in cycle N.
- Clear in cycle N: all outputs are 0 in N+1. First normal read data appears in N+2.
- If clear is raised while registers are reserved, the busy bits are dropped. Writebacks in flight then land as ordinary writes.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined:
  - A read whose address matches wr_addr with wr_en=1 (addr!=0) returns wr_data and busy=0, or busy=1 if a same-address reserve is accepted that cycle.
  - The busy output reflects the next-state busy bit, so a same-cycle reserve is seen.
- Undefined: reads return pre-edge array contents (read-before-write) and the pre-edge busy bit.

## Structure
- The shared package `rose_pkg` holds:
  - the default DATA_W and ADDR_W constants
  - the `ZERO_REG` constant (0)
  - a `reg_addr_t` typedef
- Sub-module `regfile_sb_rdport` (instantiated twice): takes an address, the array, busy and the bypass inputs, and produces the registered data and busy outputs. The scoreboard and array update logic stays in the top level.

## Test plan
- Clear, then read all addresses on both ports → rd_data=0 and busy=0 everywhere; rsv_err=0.
- Write 0xBEEF to r3 in cycle N, read r3 on A in cycle N:
  - bypass on → rd_data_a=0xBEEF in N+1
  - bypass off → 0x0000 in N+1 and 0xBEEF when read again in N+1
- Write 0x1234 to r0, then read r0 → 0x0000. Reserve r0 → busy_a=0 and rsv_err=0.
- Reserve r5, reserve r5 again the next cycle → busy_b=1, rsv_err pulses once. Write r5=0x00AA → busy clears and data reads 0x00AA.
- Same cycle: write r2=0x0F0F and reserve r2 → data 0x0F0F, busy_a=1 on the next read, no rsv_err.
- Reserve r1 and r6, assert clear together with a write to r1 → r1 reads 0, busy for r1 and r6 is 0, and all outputs are 0 in the cycle after clear.
